// File: rtl/ldm_regfile_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : ldm_regfile_writer_if
// Brief    : Command, memory-read and register-file write bundle of the
//            load-multiple sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface ldm_regfile_writer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [15:0]      reg_list;
  logic [3:0]       rn;
  logic [WIDTH-1:0] base;
  logic             up;
  logic             pre;
  logic             wb;
  logic             busy;
  logic             done;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rvalid;
  logic             WE3;
  logic [3:0]       WA3;
  logic [WIDTH-1:0] WD3;
  logic             pc_we;
  logic [WIDTH-1:0] pc_wd;

  modport slave (
    input  start, reg_list, rn, base, up, pre, wb, mem_rdata, mem_rvalid,
    output busy, done, mem_req, mem_addr, WE3, WA3, WD3, pc_we, pc_wd
  );

  modport master (
    output start, reg_list, rn, base, up, pre, wb, mem_rdata, mem_rvalid,
    input  busy, done, mem_req, mem_addr, WE3, WA3, WD3, pc_we, pc_wd
  );
endinterface
`default_nettype wire

// File: rtl/ldm_regfile_writer.sv
`default_nettype none
// ============================================================================
// Module   : ldm_regfile_writer
// Brief    : Load-multiple sequencer: one word read per listed register,
//            register-file / PC writes, then optional base writeback.
// Revision : 1.0  initial release
// ============================================================================
module ldm_regfile_writer #(
  parameter int WIDTH = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  ldm_regfile_writer_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] c_word = WIDTH'(4);

  logic [1:0]       r_state;
  logic [15:0]      r_list;
  logic [3:0]       r_rn;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wbval;
  logic             r_wb_en;
  logic             r_we3;
  logic [3:0]       r_wa3;
  logic [WIDTH-1:0] r_wd3;
  logic             r_pc_we;
  logic [WIDTH-1:0] r_pc_wd;

  logic [4:0]       w_cnt;
  logic [3:0]       w_idx;
  logic [15:0]      w_list_next;
  logic [WIDTH-1:0] w_n4;
  logic [WIDTH-1:0] w_a0;
  logic [WIDTH-1:0] w_wbval;
  logic             w_wb_en;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      w_cnt = w_cnt + {4'b0, bus.reg_list[i]};
    end
  end

  // Lowest-numbered remaining register is always the one being fetched.
  always_comb begin
    w_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_list[i]) begin
        w_idx = 4'(i);
      end
    end
  end

  assign w_list_next = r_list & ~(16'd1 << w_idx);
  assign w_n4        = WIDTH'({w_cnt, 2'b00});
  assign w_wbval     = bus.up ? (bus.base + w_n4) : (bus.base - w_n4);
  assign w_wb_en     = bus.wb && (bus.rn != 4'hF) && !bus.reg_list[bus.rn];

  always_comb begin
    case ({bus.up, bus.pre})
      2'b10:   w_a0 = bus.base;
      2'b11:   w_a0 = bus.base + c_word;
      2'b00:   w_a0 = bus.base - w_n4 + c_word;
      default: w_a0 = bus.base - w_n4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_list  <= '0;
      r_rn    <= '0;
      r_addr  <= '0;
      r_wbval <= '0;
      r_wb_en <= 1'b0;
      r_we3   <= 1'b0;
      r_wa3   <= '0;
      r_wd3   <= '0;
      r_pc_we <= 1'b0;
      r_pc_wd <= '0;
    end else begin
      r_we3   <= 1'b0;
      r_pc_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_list  <= bus.reg_list;
            r_rn    <= bus.rn;
            r_addr  <= w_a0;
            r_wbval <= w_wbval;
            r_wb_en <= w_wb_en;
            r_state <= (w_cnt == 5'd0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_rvalid) begin
            if (w_idx == 4'hF) begin
              r_pc_we <= 1'b1;
              r_pc_wd <= bus.mem_rdata;
            end else begin
              r_we3 <= 1'b1;
              r_wa3 <= w_idx;
              r_wd3 <= bus.mem_rdata;
            end
            r_list <= w_list_next;
            r_addr <= r_addr + c_word;
            if (w_list_next == 16'd0) begin
              r_state <= r_wb_en ? S_WB : S_DONE;
            end
          end
        end
        // The last load's write pulse is out during this cycle; the
        // writeback pulse lands together with done in the next one.
        S_WB: begin
          r_we3   <= 1'b1;
          r_wa3   <= r_rn;
          r_wd3   <= r_wbval;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.mem_req  = (r_state == S_REQ);
  assign bus.mem_addr = r_addr;
  assign bus.WE3      = r_we3;
  assign bus.WA3      = r_wa3;
  assign bus.WD3      = r_wd3;
  assign bus.pc_we    = r_pc_we;
  assign bus.pc_wd    = r_pc_wd;

endmodule
`default_nettype wire

// File: tb/tb_ldm_regfile_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldm_regfile_writer
// Brief    : Directed scoreboard bench for the load-multiple sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_ldm_regfile_writer;

  typedef struct {
    bit          pc;
    bit          ld;
    logic [3:0]  ra;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   waits  = 0;
  int   wcnt   = 0;
  logic stray  = 1'b0;
  logic prev_rv = 1'b0;
  logic [31:0] last_addr = '0;

  logic [31:0] exp_addr[$];
  wr_t         exp_wr[$];

  ldm_regfile_writer_if #(.WIDTH(32)) bus ();

  ldm_regfile_writer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory: fixed number of wait states per read, optional stray rvalid.
  assign bus.mem_rvalid = (bus.mem_req && (wcnt == waits)) || stray;
  assign bus.mem_rdata  = mdata(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_req && !(wcnt == waits)) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ld(input logic [31:0] a, input logic [3:0] ra);
    wr_t e;
    e.pc = (ra == 4'hF);
    e.ld = 1'b1;
    e.ra = ra;
    e.d  = mdata(a);
    exp_addr.push_back(a);
    exp_wr.push_back(e);
  endtask

  task automatic push_wb(input logic [3:0] ra, input logic [31:0] v);
    wr_t e;
    e.pc = 1'b0;
    e.ld = 1'b0;
    e.ra = ra;
    e.d  = v;
    exp_wr.push_back(e);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_req && bus.mem_rvalid) begin
      chk("addr_pending", 32'(exp_addr.size() != 0), 32'd1);
      if (exp_addr.size() != 0) chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
    end
    if (bus.mem_req && wcnt != 0) chk("addr_hold", bus.mem_addr, last_addr);
    if (bus.WE3 || bus.pc_we) begin
      chk("we_excl", 32'(bus.WE3 & bus.pc_we), 32'd0);
      chk("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        chk("wr_is_pc", 32'(bus.pc_we), 32'(e.pc));
        if (e.pc) begin
          chk("pc_wd", bus.pc_wd, e.d);
        end else begin
          chk("WA3", 32'(bus.WA3), 32'(e.ra));
          chk("WD3", bus.WD3, e.d);
        end
        if (e.ld) chk("wr_latency", 32'(prev_rv), 32'd1);
      end
    end
    prev_rv   = bus.mem_req && bus.mem_rvalid;
    last_addr = bus.mem_addr;
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),    32'd0);
    chk({tag, "_done"},  32'(bus.done),    32'd0);
    chk({tag, "_req"},   32'(bus.mem_req), 32'd0);
    chk({tag, "_addr"},  bus.mem_addr,     32'd0);
    chk({tag, "_we3"},   32'(bus.WE3),     32'd0);
    chk({tag, "_wa3"},   32'(bus.WA3),     32'd0);
    chk({tag, "_wd3"},   bus.WD3,          32'd0);
    chk({tag, "_pcwe"},  32'(bus.pc_we),   32'd0);
    chk({tag, "_pcwd"},  bus.pc_wd,        32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [15:0] list, input logic [3:0] rn_i,
                         input logic [31:0] base_i, input logic up_i, input logic pre_i,
                         input logic wb_i, input int exp_lat, input bit poke);
    int  k;
    bit  saw = 1'b0;
    bit  got = 1'b0;
    bus.reg_list = list;
    bus.rn       = rn_i;
    bus.base     = base_i;
    bus.up       = up_i;
    bus.pre      = pre_i;
    bus.wb       = wb_i;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.mem_req) saw = 1'b1;
      if (k == 1) chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
      if (poke && k == 2) begin
        bus.start    = 1'b1;
        bus.reg_list = 16'h00FF;
      end
      if (poke && k == 3) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
    if (got) begin
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
      chk({tag, "_wr_with_done"}, 32'(bus.WE3 | bus.pc_we), 32'(list != 16'd0));
    end
    chk({tag, "_saw_req"}, 32'(saw), 32'(list != 16'd0));
    @(negedge clk);
    chk({tag, "_done_off"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    chk({tag, "_addr_q"}, 32'(exp_addr.size()), 32'd0);
    chk({tag, "_wr_q"},   32'(exp_wr.size()),   32'd0);
    exp_addr.delete();
    exp_wr.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.reg_list = '0;
    bus.rn       = '0;
    bus.base     = '0;
    bus.up       = 1'b0;
    bus.pre      = 1'b0;
    bus.wb       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // IA with writeback, zero-wait
    push_ld(32'h100, 4'd1);
    push_ld(32'h104, 4'd2);
    push_ld(32'h108, 4'd3);
    push_wb(4'd0, 32'h10C);
    run_cmd("ia_wb", 16'h000E, 4'd0, 32'h100, 1'b1, 1'b0, 1'b1, 5, 1'b0);

    // DB with writeback
    push_ld(32'h1F8, 4'd4);
    push_ld(32'h1FC, 4'd7);
    push_wb(4'd13, 32'h1F8);
    run_cmd("db_wb", 16'h0090, 4'd13, 32'h200, 1'b0, 1'b1, 1'b1, 4, 1'b0);

    // Rn in list: loaded value wins
    push_ld(32'h300, 4'd1);
    push_ld(32'h304, 4'd2);
    run_cmd("rn_in_list", 16'h0006, 4'd2, 32'h300, 1'b1, 1'b0, 1'b1, 3, 1'b0);

    // DA with writeback
    push_ld(32'h4FC, 4'd0);
    push_ld(32'h500, 4'd1);
    push_wb(4'd5, 32'h4F8);
    run_cmd("da_wb", 16'h0003, 4'd5, 32'h500, 1'b0, 1'b0, 1'b1, 4, 1'b0);

    // IB, no writeback
    push_ld(32'h604, 4'd8);
    run_cmd("ib", 16'h0100, 4'd3, 32'h600, 1'b1, 1'b1, 1'b0, 2, 1'b0);

    // PC load with two wait states; start poked while busy
    waits = 2;
    push_ld(32'h400, 4'd0);
    push_ld(32'h404, 4'd15);
    run_cmd("pc_wait", 16'h8001, 4'd9, 32'h400, 1'b1, 1'b0, 1'b0, 7, 1'b1);
    waits = 0;

    // Empty list, with a stray rvalid while idle
    stray = 1'b1;
    run_cmd("empty", 16'h0000, 4'd1, 32'h800, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    stray = 1'b0;

    // Reset after the second of four loads
    push_ld(32'h700, 4'd4);
    push_ld(32'h704, 4'd5);
    exp_addr.push_back(32'h708);
    bus.reg_list = 16'h00F0;
    bus.rn       = 4'd0;
    bus.base     = 32'h700;
    bus.up       = 1'b1;
    bus.pre      = 1'b0;
    bus.wb       = 1'b0;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");
    chk("rst_addr_q", 32'(exp_addr.size()), 32'd0);
    chk("rst_wr_q",   32'(exp_wr.size()),   32'd0);
    exp_addr.delete();
    exp_wr.delete();
    @(posedge clk);
    #1;

    // Fresh command after reset
    push_ld(32'h100, 4'd1);
    push_ld(32'h104, 4'd2);
    push_ld(32'h108, 4'd3);
    push_wb(4'd0, 32'h10C);
    run_cmd("fresh", 16'h000E, 4'd0, 32'h100, 1'b1, 1'b0, 1'b1, 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
